// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage with the IF/ID pipeline register.
//               Holds the PC and issues instruction-memory reads using a
//               req/ack handshake. Each fetched word is registered for the
//               decoder, with opcode and funct split out. The stage supports
//               downstream stalls through a one-entry hold buffer, and
//               redirects (taken branch or jump) resolved in EX.
//
// Parameters  : AW       - PC and instruction-memory address width
//               RESET_PC - word-aligned PC loaded on reset
//
// Ports       : clk          in   system clock, rising edge
//               rst          in   asynchronous reset, active low
//               imem_req     out  instruction read request
//               imem_addr    out  word-aligned fetch address
//               imem_ack     in   read data valid this cycle
//               imem_rdata   in   instruction word (valid with imem_ack)
//               stall        in   IF/ID must hold
//               redirect     in   flush and refetch from redirect_pc
//               redirect_pc  in   new fetch address (bits [1:0] ignored)
//               if_valid     out  IF/ID holds a real instruction
//               if_instr     out  registered instruction
//               if_pc4       out  PC of if_instr plus 4
//               opcode       out  if_instr[31:26]
//               funct        out  if_instr[5:0]
//
// Options     : FETCH_NOP_BUBBLE_EN - when defined, every flush or bubble
//               also loads if_instr with the NOP encoding 32'hFC00_0000.
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          if_valid,
    output logic [31:0]   if_instr,
    output logic [AW-1:0] if_pc4,
    output logic [5:0]    opcode,
    output logic [5:0]    funct
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [AW-1:0] ALIGN_MASK = {{(AW-2){1'b1}}, 2'b00};
    localparam logic [AW-1:0] PC_STEP    = {{(AW-3){1'b0}}, 3'b100};

`ifdef FETCH_NOP_BUBBLE_EN
    // opcode 6'b111111 with all other fields zero decodes as a NOP
    localparam logic [31:0] NOP_INSTR = 32'hFC00_0000;
`endif

    // ------------------------------------------------------------------
    // State encoding
    //   INIT  : one idle cycle after reset, acks ignored
    //   FETCH : request outstanding at pc
    //   HOLD  : a word was fetched during a stall and waits in the buffer
    //   DROP  : a redirect hit an outstanding request; finish the old
    //           handshake and throw its data away
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t        state_q,      state_d;
    logic [AW-1:0] pc_q,         pc_d;
    logic [AW-1:0] addr_q,       addr_d;
    logic          req_q,        req_d;
    logic          if_valid_q,   if_valid_d;
    logic [31:0]   if_instr_q,   if_instr_d;
    logic [AW-1:0] if_pc4_q,     if_pc4_d;
    logic          hold_valid_q, hold_valid_d;
    logic [31:0]   hold_instr_q, hold_instr_d;
    logic [AW-1:0] hold_pc4_q,   hold_pc4_d;

    logic [AW-1:0] pc_plus4;
    logic [AW-1:0] redirect_aligned;

    // Wraps modulo 2^AW by construction
    assign pc_plus4         = pc_q + PC_STEP;
    assign redirect_aligned = redirect_pc & ALIGN_MASK;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        req_d        = req_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc4_d     = if_pc4_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;

        if (state_q == S_INIT) begin
            // Redirects and acks are both ignored here
            state_d = S_FETCH;
            req_d   = 1'b1;
            addr_d  = pc_q;
        end else if (redirect) begin
            // Flush wins over stall: the instruction in IF/ID is wrong-path
            pc_d         = redirect_aligned;
            if_valid_d   = 1'b0;
            hold_valid_d = 1'b0;
`ifdef FETCH_NOP_BUBBLE_EN
            if_instr_d   = NOP_INSTR;
`endif
            if (req_q && !imem_ack) begin
                // The old handshake must complete on its original address
                state_d = S_DROP;
                req_d   = 1'b1;
                addr_d  = addr_q;
            end else begin
                // No request pending, or it completes now (data discarded)
                state_d = S_FETCH;
                req_d   = 1'b1;
                addr_d  = redirect_aligned;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        pc_d = pc_plus4;
                        if (!stall) begin
                            if_valid_d = 1'b1;
                            if_instr_d = imem_rdata;
                            if_pc4_d   = pc_plus4;
                            addr_d     = pc_plus4;
                        end else begin
                            // Park the word; stop fetching until decode frees
                            hold_valid_d = 1'b1;
                            hold_instr_d = imem_rdata;
                            hold_pc4_d   = pc_plus4;
                            state_d      = S_HOLD;
                            req_d        = 1'b0;
                            addr_d       = pc_plus4;
                        end
                    end else if (!stall) begin
                        // Bubble: only the valid flag is cleared by default
                        if_valid_d = 1'b0;
`ifdef FETCH_NOP_BUBBLE_EN
                        if_instr_d = NOP_INSTR;
`endif
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if_valid_d   = hold_valid_q;
                        if_instr_d   = hold_instr_q;
                        if_pc4_d     = hold_pc4_q;
                        hold_valid_d = 1'b0;
                        state_d      = S_FETCH;
                        req_d        = 1'b1;
                        addr_d       = pc_q;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        state_d = S_FETCH;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                default: begin
                    state_d = S_INIT;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_INIT;
            pc_q         <= RESET_PC & ALIGN_MASK;
            addr_q       <= RESET_PC & ALIGN_MASK;
            req_q        <= 1'b0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pc4_q     <= '0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= '0;
            hold_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc4_q     <= if_pc4_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc4    = if_pc4_q;
    // Slices of the same register, so always consistent with if_instr
    assign opcode    = if_instr_q[31:26];
    assign funct     = if_instr_q[5:0];

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A table of per-cycle
//               vectors walks through the handshake, stall, redirect and
//               wrap cases; a scoreboard then checks a randomised stream;
//               a final sequence exercises asynchronous reset mid-request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic [AW-1:0] if_pc4;
    logic [5:0]    opcode;
    logic [5:0]    funct;

    always #5 clk = ~clk;

    fetch_stage #(
        .AW       (AW),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc4      (if_pc4),
        .opcode      (opcode),
        .funct       (funct)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic [31:0] d, input logic s,
                         input logic r, input logic [31:0] p);
        imem_ack    = a;
        imem_rdata  = d;
        stall       = s;
        redirect    = r;
        redirect_pc = p;
    endtask

    // Inputs applied during one cycle, outputs expected after its edge
    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stl;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    function automatic vec_t mk(input logic a, input logic [31:0] d, input logic s,
                                input logic r, input logic [31:0] p,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ei,
                                input logic [31:0] ep);
        vec_t v;
        v.ack = a; v.rdata = d; v.stl = s; v.redir = r; v.rpc = p;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc4 = ep;
        return v;
    endfunction

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } sb_t;

    vec_t        tv[$];
    sb_t         sbq[$];
    sb_t         sb_exp;
    logic [31:0] exp_addr;
    logic        s_r, a_r;
    logic [31:0] d_r;

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst.req",    {31'b0, imem_req}, 32'h0);
        chk("rst.valid",  {31'b0, if_valid}, 32'h0);
        chk("rst.instr",  if_instr, 32'h0);
        chk("rst.pc4",    if_pc4, 32'h0);
        chk("rst.opcode", {26'b0, opcode}, 32'h0);
        chk("rst.funct",  {26'b0, funct}, 32'h0);

        // ---------------- vector table ----------------
        // ack, rdata, stall, redirect, rpc | req, addr, valid, instr, pc4
        tv.push_back(mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0));
        tv.push_back(mk(1, 32'h2008_0005, 0, 0, 32'h0,         1, 32'h4,         1, 32'h2008_0005, 32'h4));
        tv.push_back(mk(1, 32'h2008_0006, 0, 0, 32'h0,         1, 32'h8,         1, 32'h2008_0006, 32'h8));
        tv.push_back(mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h8,         0, 32'h2008_0006, 32'h8));
        tv.push_back(mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h8,         0, 32'h2008_0006, 32'h8));
        tv.push_back(mk(1, 32'h1111_0000, 0, 0, 32'h0,         1, 32'hC,         1, 32'h1111_0000, 32'hC));
        tv.push_back(mk(1, 32'h0000_0020, 1, 0, 32'h0,         0, 32'h0,         1, 32'h1111_0000, 32'hC));
        tv.push_back(mk(0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'h1111_0000, 32'hC));
        tv.push_back(mk(0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'h1111_0000, 32'hC));
        tv.push_back(mk(0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'h1111_0000, 32'hC));
        tv.push_back(mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h10,        1, 32'h0000_0020, 32'h10));
        tv.push_back(mk(0, 32'h0,         0, 1, 32'h102,       1, 32'h10,        0, 32'h0000_0020, 32'h10));
        tv.push_back(mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h10,        0, 32'h0000_0020, 32'h10));
        tv.push_back(mk(1, 32'hDEAD_BEEF, 0, 0, 32'h0,         1, 32'h100,       0, 32'h0000_0020, 32'h10));
        tv.push_back(mk(1, 32'h0C00_0100, 0, 0, 32'h0,         1, 32'h104,       1, 32'h0C00_0100, 32'h104));
        tv.push_back(mk(1, 32'hBAD0_BAD0, 0, 1, 32'h200,       1, 32'h200,       0, 32'h0C00_0100, 32'h104));
        tv.push_back(mk(1, 32'h0000_0001, 0, 0, 32'h0,         1, 32'h204,       1, 32'h0000_0001, 32'h204));
        tv.push_back(mk(0, 32'h0,         0, 1, 32'hFFFF_FFFF, 1, 32'h204,       0, 32'h0000_0001, 32'h204));
        tv.push_back(mk(1, 32'h7777_7777, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0000_0001, 32'h204));
        tv.push_back(mk(1, 32'h2008_FFFF, 0, 0, 32'h0,         1, 32'h0,         1, 32'h2008_FFFF, 32'h0));
        tv.push_back(mk(0, 32'h0,         1, 1, 32'h40,        1, 32'h0,         0, 32'h2008_FFFF, 32'h0));
        tv.push_back(mk(0, 32'h0,         0, 1, 32'h80,        1, 32'h0,         0, 32'h2008_FFFF, 32'h0));
        tv.push_back(mk(1, 32'hABCD_0000, 0, 0, 32'h0,         1, 32'h80,        0, 32'h2008_FFFF, 32'h0));
        tv.push_back(mk(1, 32'h0000_0042, 0, 0, 32'h0,         1, 32'h84,        1, 32'h0000_0042, 32'h84));
        tv.push_back(mk(1, 32'h5555_0000, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0042, 32'h84));
        tv.push_back(mk(0, 32'h0,         1, 1, 32'h300,       1, 32'h300,       0, 32'h0000_0042, 32'h84));
        tv.push_back(mk(1, 32'h0000_0003, 0, 0, 32'h0,         1, 32'h304,       1, 32'h0000_0003, 32'h304));

        rst = 1'b1;
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].ack, tv[i].rdata, tv[i].stl, tv[i].redir, tv[i].rpc);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.req", i), {31'b0, imem_req}, {31'b0, tv[i].e_req});
            if (tv[i].e_req)
                chk($sformatf("v%0d.addr", i), imem_addr, tv[i].e_addr);
            chk($sformatf("v%0d.valid", i),  {31'b0, if_valid}, {31'b0, tv[i].e_valid});
            chk($sformatf("v%0d.instr", i),  if_instr, tv[i].e_instr);
            chk($sformatf("v%0d.pc4", i),    if_pc4, tv[i].e_pc4);
            chk($sformatf("v%0d.opcode", i), {26'b0, opcode}, {26'b0, tv[i].e_instr[31:26]});
            chk($sformatf("v%0d.funct", i),  {26'b0, funct},  {26'b0, tv[i].e_instr[5:0]});
            @(negedge clk);
        end

        // ---------------- scoreboard stream ----------------
        // Memory acks randomly while requested; decode stalls randomly.
        // With stall low, a valid IF/ID after the edge is always a new word.
        exp_addr = 32'h304;
        for (int c = 0; c < 400; c++) begin
            s_r = (c < 392) && ($urandom_range(0, 3) == 0);
            a_r = imem_req && (c < 392) && ($urandom_range(0, 2) != 0);
            d_r = $urandom;
            if (imem_req)
                chk("sb.addr", imem_addr, exp_addr);
            drive(a_r, d_r, s_r, 1'b0, 32'h0);
            if (a_r) begin
                sbq.push_back({d_r, exp_addr + 32'h4});
                exp_addr = exp_addr + 32'h4;
            end
            @(posedge clk);
            #1;
            if (!s_r) begin
                chk("sb.valid", {31'b0, if_valid}, {31'b0, (sbq.size() != 0)});
                if (if_valid && sbq.size() != 0) begin
                    sb_exp = sbq.pop_front();
                    chk("sb.instr",  if_instr, sb_exp.instr);
                    chk("sb.pc4",    if_pc4, sb_exp.pc4);
                    chk("sb.opcode", {26'b0, opcode}, {26'b0, sb_exp.instr[31:26]});
                    chk("sb.funct",  {26'b0, funct},  {26'b0, sb_exp.instr[5:0]});
                end
            end
            @(negedge clk);
        end
        chk("sb.drain", sbq.size(), 32'h0);

        // ---------------- async reset mid-request ----------------
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        chk("ar.req_before", {31'b0, imem_req}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar.req_now",  {31'b0, imem_req}, 32'h0);
        chk("ar.valid",    {31'b0, if_valid}, 32'h0);
        chk("ar.instr",    if_instr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Ack was high through INIT and must have been ignored
        chk("ar.init_valid", {31'b0, if_valid}, 32'h0);
        chk("ar.init_req",   {31'b0, imem_req}, 32'h1);
        chk("ar.init_addr",  imem_addr, 32'h0);
        @(posedge clk);
        #1;
        chk("ar.first_valid", {31'b0, if_valid}, 32'h1);
        chk("ar.first_instr", if_instr, 32'h1234_5678);
        chk("ar.first_pc4",   if_pc4, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
